// File: rtl/stream_upsizer.sv
// stream_upsizer: packs narrow input lanes into wide output words.
// Lanes fill the accumulation register from the least significant lane upward.
// A word is emitted when the last lane slot is filled or when in_last closes a packet.
// Lanes that were never filled read as zero, and out_keep marks the filled lanes.
// The output register is a one-entry skid. A new word can replace the current
// word in the same edge that hands the current word to the consumer.
module stream_upsizer #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_last,
    output logic [DATA_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]            out_keep,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    input  logic                        clear
);

    localparam int IDX_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int WORD_W = DATA_WIDTH * RATIO;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

    logic [IDX_W-1:0]  idx_r;
    logic [WORD_W-1:0] acc_data_r;
    logic [RATIO-1:0]  acc_keep_r;

    logic [WORD_W-1:0] out_data_r;
    logic [RATIO-1:0]  out_keep_r;
    logic              out_last_r;
    logic              out_valid_r;

    logic              in_ready_s;
    logic              accept_s;
    logic              complete_s;
    logic              out_hs_s;
    logic [WORD_W-1:0] merged_data_s;
    logic [RATIO-1:0]  merged_keep_s;

    // Ready depends only on the output register state and out_ready.
    // This keeps the input handshake free of combinational loops.
    assign in_ready_s = !out_valid_r || out_ready;
    assign accept_s   = in_valid && in_ready_s;
    assign complete_s = accept_s && ((idx_r == IDX_LAST) || in_last);
    assign out_hs_s   = out_valid_r && out_ready;

    // Merge the offered lane into the accumulated lanes at slot idx.
    always_comb begin
        merged_data_s = acc_data_r;
        merged_keep_s = acc_keep_r;
        merged_data_s[idx_r*DATA_WIDTH +: DATA_WIDTH] = in_data;
        merged_keep_s[idx_r] = 1'b1;
    end

    // Accumulation state: lane index and the partially filled word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_r      <= '0;
            acc_data_r <= '0;
            acc_keep_r <= '0;
        end else if (clear) begin
            idx_r      <= '0;
            acc_data_r <= '0;
            acc_keep_r <= '0;
        end else if (complete_s) begin
            idx_r      <= '0;
            acc_data_r <= '0;
            acc_keep_r <= '0;
        end else if (accept_s) begin
            idx_r      <= idx_r + IDX_W'(1);
            acc_data_r <= merged_data_s;
            acc_keep_r <= merged_keep_s;
        end else begin
            idx_r      <= idx_r;
            acc_data_r <= acc_data_r;
            acc_keep_r <= acc_keep_r;
        end
    end

    // Output register: load on completion, drop valid on a bare handshake, else hold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_data_r  <= '0;
            out_keep_r  <= '0;
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (clear) begin
            out_data_r  <= '0;
            out_keep_r  <= '0;
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (complete_s) begin
            out_data_r  <= merged_data_s;
            out_keep_r  <= merged_keep_s;
            out_last_r  <= in_last;
            out_valid_r <= 1'b1;
        end else if (out_hs_s) begin
            out_data_r  <= out_data_r;
            out_keep_r  <= out_keep_r;
            out_last_r  <= out_last_r;
            out_valid_r <= 1'b0;
        end else begin
            out_data_r  <= out_data_r;
            out_keep_r  <= out_keep_r;
            out_last_r  <= out_last_r;
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_keep  = out_keep_r;
    assign out_last  = out_last_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_stream_upsizer.sv
// Testbench for stream_upsizer with DATA_WIDTH=8 and RATIO=4.
// It runs a fixed vector table, then hand-written corner sequences,
// then random traffic checked against a lane-queue model.
module tb_stream_upsizer;

    localparam int DW = 8;
    localparam int R  = 4;
    localparam int WW = DW * R;

    logic          clk;
    logic          rstn;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [WW-1:0] out_data;
    logic [R-1:0]  out_keep;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          clear;

    stream_upsizer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
        .clk(clk), .rstn(rstn),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .clear(clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Compare one value against its expectation and report on mismatch.
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          l;
        logic          ordy;
        logic          clr;
        logic          e_rdy;
        logic          e_valid;
        logic [WW-1:0] e_data;
        logic [R-1:0]  e_keep;
        logic          e_last;
        logic          cmp_pl;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l, input logic ordy,
                                input logic clr, input logic e_rdy, input logic e_valid,
                                input logic [31:0] e_data, input logic [3:0] e_keep,
                                input logic e_last, input logic cmp_pl);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.ordy = ordy; t.clr = clr;
        t.e_rdy = e_rdy; t.e_valid = e_valid; t.e_data = e_data;
        t.e_keep = e_keep; t.e_last = e_last; t.cmp_pl = cmp_pl;
        return t;
    endfunction

    // ---------------- reference model ----------------
    logic [DW-1:0] m_lanes[$];
    logic          m_valid;
    logic [WW-1:0] m_data;
    logic [R-1:0]  m_keep;
    logic          m_last;
    int            m_words;
    logic          m_acc;

    task automatic model_reset();
        m_lanes.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_keep  = '0;
        m_last  = 1'b0;
    endtask

    // Drive one cycle, step the model, and check the DUT against it.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l,
                         input logic ordy, input logic clr);
        logic e_rdy;
        logic hs;
        logic done;
        in_valid = v; in_data = d; in_last = l; out_ready = ordy; clear = clr;
        #1;
        e_rdy = !m_valid || ordy;
        chk("in_ready", in_ready, e_rdy);
        m_acc = v && e_rdy && !clr;
        if (clr) begin
            model_reset();
        end else begin
            hs   = m_valid && ordy;
            done = 1'b0;
            if (m_acc) begin
                m_lanes.push_back(d);
                if (m_lanes.size() == R || l) begin
                    m_data = '0;
                    for (int i = 0; i < m_lanes.size(); i++)
                        m_data = m_data | (WW'(m_lanes[i]) << (DW * i));
                    m_keep  = R'((1 << m_lanes.size()) - 1);
                    m_last  = l;
                    m_valid = 1'b1;
                    m_lanes.delete();
                    m_words++;
                    done = 1'b1;
                end
            end
            if (!done && hs) m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_valid);
        if (m_valid || clr) begin
            chk("out_data", out_data, m_data);
            chk("out_keep", out_keep, m_keep);
            chk("out_last", out_last, m_last);
        end
    endtask

    // Assert reset asynchronously, check its immediate effect, then release it.
    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_keep", out_keep, '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_last", out_last, 1'b0);
        model_reset();
        in_valid = 1'b0; clear = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc_cnt;
        int lane;
        int budget;
        int w0;

        rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        out_ready = 1'b0; clear = 1'b0;
        m_words = 0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_valid0", out_valid, 1'b0);
        chk("rst_keep0", out_keep, '0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // Table rows cover a full word, a partial packet, a single-lane packet,
        // a stall, a clear mid-word, and a clear while a word is stalled.
        tbl[0]  = mk(1, 8'h11, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 0);
        tbl[1]  = mk(1, 8'h22, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 0);
        tbl[2]  = mk(1, 8'h33, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 0);
        tbl[3]  = mk(1, 8'h44, 0, 1, 0, 1, 1, 32'h44332211, 4'hF, 0, 1);
        tbl[4]  = mk(1, 8'hAA, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 0);
        tbl[5]  = mk(1, 8'hBB, 1, 1, 0, 1, 1, 32'h0000BBAA, 4'h3, 1, 1);
        tbl[6]  = mk(1, 8'h55, 1, 1, 0, 1, 1, 32'h00000055, 4'h1, 1, 1);
        tbl[7]  = mk(1, 8'h66, 0, 0, 0, 0, 1, 32'h00000055, 4'h1, 1, 1);
        tbl[8]  = mk(1, 8'h66, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 0);
        tbl[9]  = mk(1, 8'h77, 0, 1, 1, 1, 0, 32'h0, 4'h0, 0, 1);
        tbl[10] = mk(1, 8'h01, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 0);
        tbl[11] = mk(1, 8'h02, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 0);
        tbl[12] = mk(1, 8'h03, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 0);
        tbl[13] = mk(1, 8'h04, 0, 1, 0, 1, 1, 32'h04030201, 4'hF, 0, 1);
        tbl[14] = mk(0, 8'h00, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 0);
        tbl[15] = mk(1, 8'hA1, 0, 0, 0, 1, 0, 32'h0, 4'h0, 0, 0);
        tbl[16] = mk(1, 8'hA2, 0, 0, 0, 1, 0, 32'h0, 4'h0, 0, 0);
        tbl[17] = mk(1, 8'hA3, 0, 0, 0, 1, 0, 32'h0, 4'h0, 0, 0);
        tbl[18] = mk(1, 8'hA4, 0, 0, 0, 1, 1, 32'hA4A3A2A1, 4'hF, 0, 1);
        tbl[19] = mk(1, 8'hB1, 0, 0, 1, 0, 0, 32'h0, 4'h0, 0, 1);
        tbl[20] = mk(0, 8'h00, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            in_valid = tbl[i].v; in_data = tbl[i].d; in_last = tbl[i].l;
            out_ready = tbl[i].ordy; clear = tbl[i].clr;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_valid);
            if (tbl[i].cmp_pl) begin
                chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_data);
                chk($sformatf("tbl%0d_out_keep", i), out_keep, tbl[i].e_keep);
                chk($sformatf("tbl%0d_out_last", i), out_last, tbl[i].e_last);
            end
        end
        clear = 1'b0;

        // Backpressure: eight lanes offered while the consumer stalls.
        acc_cnt = 0;
        lane = 0;
        for (int c = 0; c < 8; c++) begin
            cycle(1'b1, DW'(8'h81 + lane), 1'b0, 1'b0, 1'b0);
            if (m_acc) begin
                acc_cnt++;
                lane++;
            end
        end
        chk("bp_accepted_while_stalled", acc_cnt, 4);
        w0 = m_words;
        budget = 0;
        while (lane < 8 && budget < 20) begin
            cycle(1'b1, DW'(8'h81 + lane), 1'b0, 1'b1, 1'b0);
            if (m_acc) lane++;
            budget++;
        end
        chk("bp_all_lanes_accepted", lane, 8);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("bp_words_after_release", m_words - w0, 1);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Streaming: 64 random lanes back-to-back should give 16 words.
        w0 = m_words;
        for (int i = 0; i < 64; i++)
            cycle(1'b1, DW'($urandom), 1'b0, 1'b1, 1'b0);
        chk("stream_words", m_words - w0, 16);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Reset while a stalled word is valid, then check the next word starts clean.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        chk("pre_reset_valid", out_valid, 1'b1);
        out_ready = 1'b0;
        do_reset();
        chk("post_reset_in_ready", in_ready, 1'b1);
        cycle(1'b1, 8'hD1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'hD2, 1'b1, 1'b1, 1'b0);
        chk("post_reset_word", out_data, 32'h0000D2D1);

        // Reset with a partially filled word, then push a full word.
        cycle(1'b1, 8'hE1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'hE2, 1'b0, 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++)
            cycle(1'b1, DW'(8'hF1 + i), 1'b0, 1'b1, 1'b0);
        chk("partial_reset_word", out_data, 32'hF4F3F2F1);

        // Random mix of valid, last, ready and clear.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
